// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and small helpers for the
// sequential ALU and its iterative multiplier.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_LUI  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SGT  = 4'b1000;
  localparam logic [3:0] OP_SLE  = 4'b1001;
  localparam logic [3:0] OP_SGE  = 4'b1010;
  localparam logic [3:0] OP_SEQ  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_SNE  = 4'b1110;
  localparam logic [3:0] OP_SRLV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement overflow of an addition from the operand and result sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative signed multiplier: magnitudes are multiplied by shift-add, one
// partial product per cycle, and the sign is applied to the 2*WIDTH product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic               active_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;

  // One shift-add step: {hi, lo} with the multiplier consumed from lo[0].
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    if (p[0]) begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
    end else begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]};
    end
    return {sum, p[WIDTH-1:1]};
  endfunction

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    if (a_i[WIDTH-1]) begin
      a_mag_s = (~a_i) + ONE_W;
    end else begin
      a_mag_s = a_i;
    end
    if (b_i[WIDTH-1]) begin
      b_mag_s = (~b_i) + ONE_W;
    end else begin
      b_mag_s = b_i;
    end
  end

  // The first step runs on the start edge so WIDTH steps finish WIDTH-1 cycles later.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= {(2*WIDTH){1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else if (start_i) begin
      prod_q   <= mul_step({{WIDTH{1'b0}}, b_mag_s}, a_mag_s);
      mcand_q  <= a_mag_s;
      neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      active_q <= 1'b1;
      cnt_q    <= CNT_ONE;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        active_q <= 1'b0;
      end else begin
        prod_q <= mul_step(prod_q, mcand_q);
        cnt_q  <= cnt_q + CNT_ONE;
      end
    end
  end

  assign busy_o    = active_q;
  assign done_o    = active_q && (cnt_q == CNT_LAST);
  assign product_o = neg_q ? ((~prod_q) + ONE_2W) : prod_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic ops and an
// iterative signed multiplier, results held until the consumer accepts them.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [3:0]         ctrl_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic [WIDTH-1:0]   result_hi_o,
  output logic               zero_o,
  output logic               overflow_o
);

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic               accept_s;
  logic               is_mul_s;
  logic               ld_alu_s;
  logic               ld_mul_s;
  logic               clr_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_ovf_s;
  logic               lt_s;
  logic               eq_s;
  logic               mul_busy_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  assign ready_o  = (state_q == IDLE) || ((state_q == DONE) && ready_i);
  assign accept_s = valid_i && ready_o;
  assign is_mul_s = (ctrl_i == OP_MULT);
  assign lt_s     = $signed(src1_i) < $signed(src2_i);
  assign eq_s     = (src1_i == src2_i);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .start_i   (accept_s && is_mul_s),
    .a_i       (src1_i),
    .b_i       (src2_i),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  // Single-cycle datapath for every opcode except multiply.
  always_comb begin
    alu_res_s = ZERO_W;
    alu_ovf_s = 1'b0;
    case (ctrl_i)
      OP_AND:  alu_res_s = src1_i & src2_i;
      OP_OR:   alu_res_s = src1_i | src2_i;
      OP_NOR:  alu_res_s = ~(src1_i | src2_i);
      OP_NAND: alu_res_s = ~(src1_i & src2_i);
      OP_ADD: begin
        alu_res_s = src1_i + src2_i;
        alu_ovf_s = add_ovf(src1_i[WIDTH-1], src2_i[WIDTH-1], alu_res_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = src1_i - src2_i;
        alu_ovf_s = add_ovf(src1_i[WIDTH-1], ~src2_i[WIDTH-1], alu_res_s[WIDTH-1]);
      end
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SGT:  alu_res_s = {{(WIDTH-1){1'b0}}, !lt_s && !eq_s};
      OP_SLE:  alu_res_s = {{(WIDTH-1){1'b0}}, lt_s || eq_s};
      OP_SGE:  alu_res_s = {{(WIDTH-1){1'b0}}, !lt_s};
      OP_SEQ:  alu_res_s = {{(WIDTH-1){1'b0}}, eq_s};
      OP_SNE:  alu_res_s = {{(WIDTH-1){1'b0}}, !eq_s};
      OP_SLL:  alu_res_s = src2_i << shamt_i;
      OP_SRLV: alu_res_s = (src1_i >= WIDTH_V) ? ZERO_W : (src2_i >> src1_i);
      OP_LUI:  alu_res_s = src2_i << (WIDTH / 2);
      OP_MULT: alu_res_s = ZERO_W;
      default: alu_res_s = ZERO_W;
    endcase
  end

  // Next state and which source, if any, loads the result registers.
  always_comb begin
    state_d  = state_q;
    ld_alu_s = 1'b0;
    ld_mul_s = 1'b0;
    clr_s    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s && is_mul_s) begin
          state_d = MUL;
          clr_s   = 1'b1;
        end else if (accept_s) begin
          state_d  = DONE;
          ld_alu_s = 1'b1;
        end else if ((state_q == DONE) && ready_i) begin
          state_d = IDLE;
          clr_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          state_d  = DONE;
          ld_mul_s = 1'b1;
        end else if (mul_busy_s) begin
          state_d = MUL;
        end else begin
          state_d = IDLE;
          clr_s   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr_s   = 1'b1;
      end
    endcase
  end

  // Output register next values; held unless loaded or retired.
  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    valid_d     = valid_q;
    if (ld_alu_s) begin
      result_d    = alu_res_s;
      result_hi_d = ZERO_W;
      zero_d      = (alu_res_s == ZERO_W);
      ovf_d       = alu_ovf_s;
      valid_d     = 1'b1;
    end else if (ld_mul_s) begin
      result_d    = mul_prod_s[WIDTH-1:0];
      result_hi_d = mul_prod_s[2*WIDTH-1:WIDTH];
      zero_d      = (mul_prod_s[WIDTH-1:0] == ZERO_W);
      ovf_d       = 1'b0;
      valid_d     = 1'b1;
    end else if (clr_s) begin
      result_d    = ZERO_W;
      result_hi_d = ZERO_W;
      zero_d      = 1'b0;
      ovf_d       = 1'b0;
      valid_d     = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= ZERO_W;
      result_hi_q <= ZERO_W;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
    end
  end

  assign valid_o     = valid_q;
  assign result_o    = result_q;
  assign result_hi_o = result_hi_q;
  assign zero_o      = zero_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed and random ops checked
// against an arithmetic reference model, including handshake timing and reset abort.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [3:0]    ctrl_i = 4'd0;
  logic [W-1:0]  src1_i = '0;
  logic [W-1:0]  src2_i = '0;
  logic [4:0]    shamt_i = 5'd0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [W-1:0]  result_o;
  logic [W-1:0]  result_hi_o;
  logic          zero_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ctrl_i      (ctrl_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .shamt_i     (shamt_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .result_hi_o (result_hi_o),
    .zero_o      (zero_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain signed 64-bit arithmetic on the operands.
  function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output logic [31:0] lo,
                                 output logic [31:0] hi, output logic ovf);
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = 32'd0; hi = 32'd0; ovf = 1'b0;
    case (c)
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0010: begin r = sa + sb; lo = r[31:0]; ovf = (r != longint'($signed(lo))); end
      4'b0110: begin r = sa - sb; lo = r[31:0]; ovf = (r != longint'($signed(lo))); end
      4'b1100: lo = ~(a | b);
      4'b1101: lo = ~(a & b);
      4'b0111: lo = (sa <  sb) ? 32'd1 : 32'd0;
      4'b1000: lo = (sa >  sb) ? 32'd1 : 32'd0;
      4'b1001: lo = (sa <= sb) ? 32'd1 : 32'd0;
      4'b1010: lo = (sa >= sb) ? 32'd1 : 32'd0;
      4'b1011: lo = (a == b) ? 32'd1 : 32'd0;
      4'b1110: lo = (a != b) ? 32'd1 : 32'd0;
      4'b0011: begin r = sa * sb; p = r; hi = p[63:32]; lo = p[31:0]; end
      4'b0101: lo = b << sh;
      4'b1111: lo = (a >= 32'd32) ? 32'd0 : (b >> a);
      4'b0100: lo = b << 16;
      default: lo = 32'd0;
    endcase
  endfunction

  task automatic chk_out(input logic [31:0] lo, input logic [31:0] hi, input logic ovf);
    chk("valid", valid_o, 1);
    chk("result", result_o, lo);
    chk("result_hi", result_hi_o, hi);
    chk("zero", zero_o, (lo == 32'd0));
    chk("overflow", overflow_o, ovf);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // One op from IDLE: check accept, latency, ready_o low time, result, hold while stalled, retire.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input int stall);
    logic [31:0] elo, ehi;
    logic eovf;
    int lat, low;
    bit m;
    ref_op(c, a, b, sh, elo, ehi, eovf);
    m = (c == 4'b0011);
    @(negedge clk_i);
    ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh; valid_i = 1'b1; ready_i = 1'b0;
    chk("ready_idle", ready_o, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    ctrl_i = 4'($urandom); src1_i = $urandom; src2_i = $urandom; shamt_i = 5'($urandom);
    lat = 1; low = 0;
    while (!valid_o && lat < 100) begin
      if (!ready_o) low++;
      @(negedge clk_i);
      lat++;
    end
    chk("latency", lat, m ? 33 : 1);
    chk("ready_low_cycles", low, m ? 32 : 0);
    chk_out(elo, ehi, eovf);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i);
      chk_out(elo, ehi, eovf);
    end
    ready_i = 1'b1;
    #1;
    chk("ready_done", ready_o, 1);
    @(negedge clk_i);
    chk("retired", valid_o, 0);
    ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] plo, phi, elo, ehi;
    logic        povf, eovf;
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [4:0]  sh;
    int          seen;

    repeat (2) @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_result_hi", result_hi_o, 0);
    chk("rst_zero", zero_o, 0);
    chk("rst_overflow", overflow_o, 0);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("ready_after_rst", ready_o, 1);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    run_op(4'b0011, 32'hFFFF_FFFD, 32'h0000_0005, 5'd0, 0);
    run_op(4'b0011, 32'h8000_0000, 32'h8000_0000, 5'd0, 1);
    run_op(4'b1111, 32'd40, 32'h0000_00F0, 5'd0, 0);
    run_op(4'b1111, 32'd4, 32'h0000_00F0, 5'd0, 0);
    run_op(4'b0101, 32'd0, 32'h0000_0001, 5'd4, 0);
    run_op(4'b0100, 32'd0, 32'h0000_1234, 5'd0, 0);
    run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0, 0);

    // slt stalled three cycles, then a sub accepted on the retiring edge
    @(negedge clk_i);
    ctrl_i = 4'b0111; src1_i = 32'hFFFF_FFFF; src2_i = 32'd1; valid_i = 1'b1; ready_i = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    chk_out(32'd1, 32'd0, 1'b0);
    repeat (3) begin
      @(negedge clk_i);
      chk_out(32'd1, 32'd0, 1'b0);
    end
    ctrl_i = 4'b0110; src1_i = 32'd5; src2_i = 32'd5; valid_i = 1'b1; ready_i = 1'b1;
    #1;
    chk("ready_b2b", ready_o, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk_out(32'd0, 32'd0, 1'b0);
    @(negedge clk_i);
    chk("b2b_retired", valid_o, 0);
    ready_i = 1'b0;

    // Back-to-back non-mult stream at one op per cycle
    plo = '0; phi = '0; povf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (i > 0) chk_out(plo, phi, povf);
      c = 4'($urandom_range(0, 15));
      if (c == 4'b0011) c = 4'b0010;
      a = rnd_val(); b = rnd_val(); sh = 5'($urandom);
      ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh; valid_i = 1'b1; ready_i = 1'b1;
      ref_op(c, a, b, sh, plo, phi, povf);
    end
    @(negedge clk_i);
    chk_out(plo, phi, povf);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("stream_retired", valid_o, 0);
    ready_i = 1'b0;

    for (int i = 0; i < 30; i++) begin
      run_op(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 5'($urandom), $urandom_range(0, 2));
    end

    // Reset in the middle of a multiply
    @(negedge clk_i);
    ctrl_i = 4'b0011; src1_i = 32'd7; src2_i = 32'd9; valid_i = 1'b1; ready_i = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    chk("mul_ready_low", ready_o, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", valid_o, 0);
    chk("abort_result", result_o, 0);
    chk("abort_result_hi", result_hi_o, 0);
    chk("abort_zero", zero_o, 0);
    chk("abort_overflow", overflow_o, 0);
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", ready_o, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    chk("abort_no_valid", seen, 0);

    ref_op(4'b0011, 32'h0001_0000, 32'hFFFF_0000, 5'd0, elo, ehi, eovf);
    run_op(4'b0011, 32'h0001_0000, 32'hFFFF_0000, 5'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
